cpu_controller: RTL and testbench
=================================

# cpu_controller

Instruction sequencer for the 8-bit accumulator CPU. It drives the ALU `opcode` path and consumes the ALU `isZero` flag. It steps a fixed 8-phase fetch/execute cycle and decodes the 3-bit opcode from the instruction register into datapath strobes: PC, IR, accumulator, memory and bus enable. It inserts wait states on a memory-ready handshake and halts on HLT or on a memory timeout.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum consecutive `mem_rdy`-low cycles tolerated in a wait phase before a bus error is flagged.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  3  IR opcode field. HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- `zero`  in  1  ALU `isZero` (accumulator == 0).
- `mem_rdy`  in  1  memory completes the current read/write this cycle.
- `sel`  out  1  address mux selects PC (1) or IR operand (0).
- `rd`  out  1  memory read enable.
- `wr`  out  1  memory write enable.
- `ld_ir`  out  1  load instruction register.
- `ld_ac`  out  1  load accumulator from ALU result.
- `ld_pc`  out  1  load PC from IR operand.
- `inc_pc`  out  1  increment PC.
- `data_e`  out  1  drive accumulator onto the data bus.
- `halt`  out  1  CPU halted (sticky).
- `bus_err`  out  1  memory timeout occurred (sticky).
- `phase`  out  3  current phase, for debug.
- `instr_cnt`  out  8  count of retired instructions, wraps modulo 256.

## Operation
- ALUOP = ADD | AND | XOR | LDA.
- Registered state: `phase`, `halted`, `bus_err`, `wait_cnt` (width clog2(WAIT_MAX+1)), `instr_cnt`.
- Strobes are a combinational decode of `phase`, `opcode` and `zero`. When `halted` is 1, every strobe is 0 and `halt` is 1.
- Strobe decode per phase:
  - 0 INST_ADDR: `sel`.
  - 1 INST_FETCH: `sel`, `rd`.
  - 2 INST_LOAD: `sel`, `rd`, `ld_ir`.
  - 3 IDLE: `sel`, `rd`, `ld_ir`.
  - 4 OP_ADDR: `inc_pc` = !HLT; `halt` = HLT.
  - 5 OP_FETCH: `rd` = ALUOP.
  - 6 ALU_OP: `rd` = ALUOP; `inc_pc` = SKZ & `zero`; `ld_pc` = JMP; `data_e` = STO.
  - 7 STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `ld_pc` = JMP; `data_e` = STO; `wr` = STO.
- Wait phases: phase 1 always; phase 5 when ALUOP; phase 7 when STO.
  - In a wait phase with `mem_rdy`=0, `phase` holds, strobes hold, and `wait_cnt` increments.
  - With `mem_rdy`=1, the phase advances and `wait_cnt` clears.
  - `wait_cnt` clears on every phase advance.
- Timeout: if `mem_rdy`=0 in a wait phase while `wait_cnt`==WAIT_MAX-1, set `bus_err`=1 and `halted`=1 on that edge.
- All other phases advance unconditionally, modulo 8.
- HLT: in phase 4 with opcode HLT, `halted` sets on the edge and `phase` freezes at 4. Only `rst_n` clears `halted`.
- Retirement: each 7→0 transition increments `instr_cnt`, wrapping 255→0.
- SKZ with `zero`=0, and HLT, retire no further strobes beyond those in the decode above.

## Timing
- Reset (async assert, release synchronous to `clk`):
  - State: `phase`=0, `halted`=0, `bus_err`=0, `wait_cnt`=0, `instr_cnt`=0.
  - Outputs during and after reset: `sel`=1, `halt`=0, all other strobes 0.
- Nominal instruction: 8 cycles. Each wait phase adds one cycle per `mem_rdy`-low cycle.
- `rst_n` asserted mid-instruction returns to phase 0 immediately and clears all counters. No partial strobe persists.
- `opcode` must be stable from phase 4 through phase 7. IR loads at the end of phase 3.
- `zero` is sampled combinationally only in phase 6.
- Simultaneous timeout and `mem_rdy`=1 on the same cycle: `mem_rdy` wins; advance with no error.
- `halted` or `bus_err` set: `instr_cnt` frozen; inputs ignored until reset.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (HLT…JMP);
  - phase constants (INST_ADDR…STORE);
  - ALUOP membership function.
- The ALU uses the same opcode constants from `cpu_pkg`.
- Sub-module `cpu_wait_timer`: `wait_cnt` plus the timeout compare. Ports: `clk`, `rst_n`, `clr`, `inc`, `expire`.

## Test plan
- Reset, then `mem_rdy`=1, opcode=ADD: phases 0..7 in 8 cycles; `ld_ac`=1 only in phase 7; `instr_cnt`=1 after the first 7→0 transition.
- SKZ with `zero`=1 gives `inc_pc` in phases 4 and 6. SKZ with `zero`=0 gives `inc_pc` in phase 4 only.
- JMP: `ld_pc`=1 in phases 6–7; `rd`=0 and `wr`=0 throughout phases 4–7.
- STO with `mem_rdy` low for 3 cycles in phase 7: phase holds 3 extra cycles with `wr`=`data_e`=1; the instruction retires on cycle 11.
- `mem_rdy` held 0 in phase 1 with WAIT_MAX=15: `bus_err`=`halt`=1 after the 15th wait cycle, all strobes 0 thereafter. Asserting `rst_n` low clears to phase 0, `sel`=1.
- HLT: `halt`=1 in phase 4, `inc_pc`=0, phase stays 4 for 20 cycles. 256 ADDs wrap `instr_cnt` to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode and phase encodings for the 8-bit accumulator CPU.
// The ALU decodes the same opcode_t constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle on which
// one more stall would exceed WAIT_MAX.
module cpu_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int W = $clog2(WAIT_MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(WAIT_MAX - 1);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expire = inc && (wait_cnt == LIMIT);

endmodule

// File: rtl/cpu_controller.sv
// Fixed 8-phase fetch/execute sequencer with memory wait states,
// HLT handling and a sticky bus-timeout halt.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       data_e,
    output logic       halt,
    output logic       bus_err,
    output logic [2:0] phase,
    output logic [7:0] instr_cnt
);

    phase_t  state;
    opcode_t op;
    logic    halted;
    logic    aluop;
    logic    wait_phase;
    logic    stall;
    logic    expire;
    logic    halt_dec;

    assign op         = opcode_t'(opcode);
    assign aluop      = is_aluop(op);
    assign wait_phase = (state == INST_FETCH) ||
                        (state == OP_FETCH && aluop) ||
                        (state == STORE && op == STO);
    assign stall      = wait_phase && !mem_rdy;
    assign phase      = state;
    assign halt       = halted || halt_dec;

    cpu_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!halted && !stall),
        .inc   (!halted && stall),
        .expire(expire)
    );

    // Once halted, nothing but reset moves the sequencer or the retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INST_ADDR;
            halted    <= 1'b0;
            bus_err   <= 1'b0;
            instr_cnt <= '0;
        end else if (!halted) begin
            if (stall) begin
                if (expire) begin
                    bus_err <= 1'b1;
                    halted  <= 1'b1;
                end
            end else if (state == OP_ADDR && op == HLT) begin
                halted <= 1'b1;
            end else begin
                state <= phase_t'(state + 3'd1);
                if (state == STORE) begin
                    instr_cnt <= instr_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        sel      = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        ld_ir    = 1'b0;
        ld_ac    = 1'b0;
        ld_pc    = 1'b0;
        inc_pc   = 1'b0;
        data_e   = 1'b0;
        halt_dec = 1'b0;
        if (!halted) begin
            case (state)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc   = (op != HLT);
                    halt_dec = (op == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (op == SKZ) && zero;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                    wr     = (op == STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a behavioural model predicts every
// cycle's outputs, plus targeted checks on phase masks, latency and wrap.
module tb_cpu_controller;

    localparam int WAIT_MAX = 15;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam int B_SEL  = 8;
    localparam int B_RD   = 7;
    localparam int B_WR   = 6;
    localparam int B_IR   = 5;
    localparam int B_AC   = 4;
    localparam int B_PC   = 3;
    localparam int B_INC  = 2;
    localparam int B_DE   = 1;
    localparam int B_HALT = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic [8:0] strb;
        logic       err;
        logic [7:0] cnt;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rdy;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, bus_err;
    logic [2:0] phase;
    logic [7:0] instr_cnt;

    snap_t got;
    snap_t exp_q[$];

    logic [2:0] m_phase;
    logic [7:0] m_cnt;
    int         m_wait;
    logic       m_halted;
    logic       m_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cpu_controller #(
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .zero     (zero),
        .mem_rdy  (mem_rdy),
        .sel      (sel),
        .rd       (rd),
        .wr       (wr),
        .ld_ir    (ld_ir),
        .ld_ac    (ld_ac),
        .ld_pc    (ld_pc),
        .inc_pc   (inc_pc),
        .data_e   (data_e),
        .halt     (halt),
        .bus_err  (bus_err),
        .phase    (phase),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign got = {phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, bus_err, instr_cnt};

    function automatic logic is_alu();
        return (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_XOR) || (opcode == OP_LDA);
    endfunction

    // Expected outputs written straight from the per-phase strobe table.
    function automatic snap_t model_snap();
        snap_t s;
        s      = '0;
        s.ph   = m_phase;
        s.err  = m_err;
        s.cnt  = m_cnt;
        if (m_halted) begin
            s.strb[B_HALT] = 1'b1;
        end else begin
            case (m_phase)
                3'd0: s.strb[B_SEL] = 1'b1;
                3'd1: begin s.strb[B_SEL] = 1'b1; s.strb[B_RD] = 1'b1; end
                3'd2, 3'd3: begin
                    s.strb[B_SEL] = 1'b1; s.strb[B_RD] = 1'b1; s.strb[B_IR] = 1'b1;
                end
                3'd4: begin
                    s.strb[B_INC]  = (opcode != OP_HLT);
                    s.strb[B_HALT] = (opcode == OP_HLT);
                end
                3'd5: s.strb[B_RD] = is_alu();
                3'd6: begin
                    s.strb[B_RD]  = is_alu();
                    s.strb[B_INC] = (opcode == OP_SKZ) && zero;
                    s.strb[B_PC]  = (opcode == OP_JMP);
                    s.strb[B_DE]  = (opcode == OP_STO);
                end
                default: begin
                    s.strb[B_RD] = is_alu();
                    s.strb[B_AC] = is_alu();
                    s.strb[B_PC] = (opcode == OP_JMP);
                    s.strb[B_DE] = (opcode == OP_STO);
                    s.strb[B_WR] = (opcode == OP_STO);
                end
            endcase
        end
        return s;
    endfunction

    task automatic model_reset();
        m_phase  = 3'd0;
        m_cnt    = 8'd0;
        m_wait   = 0;
        m_halted = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_edge();
        logic waits;
        waits = (m_phase == 3'd1) || (m_phase == 3'd5 && is_alu()) ||
                (m_phase == 3'd7 && opcode == OP_STO);
        if (!rst_n) begin
            model_reset();
        end else if (!m_halted) begin
            if (waits && !mem_rdy) begin
                if (m_wait == WAIT_MAX - 1) begin
                    m_err    = 1'b1;
                    m_halted = 1'b1;
                end else begin
                    m_wait++;
                end
            end else if (m_phase == 3'd4 && opcode == OP_HLT) begin
                m_halted = 1'b1;
            end else begin
                if (m_phase == 3'd7) m_cnt = m_cnt + 8'd1;
                m_phase = m_phase + 3'd1;
                m_wait  = 0;
            end
        end
    endtask

    task automatic push_cycle();
        exp_q.push_back(model_snap());
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        finish_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        snap_t e;
        opcode = OP_ADD; mem_rdy = 1'b1; zero = 1'b0;
        for (int c = 0; c < 5; c++) begin
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL reset_run%0d got=%h exp=%h", c, got, e);
            else pass_cnt++;
            finish_cycle();
        end
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL reset_hold%0d got=%h exp=%h", c, got, e);
            else pass_cnt++;
            finish_cycle();
        end
        total_cnt++;
        if ({phase, sel, rd, ld_ir, halt} !== 7'b000_1000)
            $display("[TB] FAIL reset_outputs got=%b exp=%b", {phase, sel, rd, ld_ir, halt}, 7'b000_1000);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        snap_t e;
        logic [7:0] ac_mask;
        ac_mask = '0;
        opcode = OP_ADD; mem_rdy = 1'b1; zero = 1'b0;
        for (int c = 0; c < 8; c++) begin
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL add_cyc%0d got=%h exp=%h", c, got, e);
            else pass_cnt++;
            if (ld_ac) ac_mask[phase] = 1'b1;
            finish_cycle();
        end
        total_cnt++;
        if (ac_mask !== 8'h80) $display("[TB] FAIL add_ldac_mask got=%h exp=80", ac_mask);
        else pass_cnt++;
        total_cnt++;
        if (instr_cnt !== 8'd1 || phase !== 3'd0)
            $display("[TB] FAIL add_retire got=%0d/%0d exp=1/0", instr_cnt, phase);
        else pass_cnt++;
    endtask

    task automatic test_skz();
        snap_t e;
        logic [7:0] inc_mask;
        for (int z = 1; z >= 0; z--) begin
            inc_mask = '0;
            opcode = OP_SKZ; mem_rdy = 1'b1; zero = (z == 1);
            for (int c = 0; c < 8; c++) begin
                push_cycle();
                e = exp_q.pop_front();
                total_cnt++;
                if (got !== e) $display("[TB] FAIL skz%0d_cyc%0d got=%h exp=%h", z, c, got, e);
                else pass_cnt++;
                if (inc_pc) inc_mask[phase] = 1'b1;
                finish_cycle();
            end
            total_cnt++;
            if (inc_mask !== ((z == 1) ? 8'h50 : 8'h10))
                $display("[TB] FAIL skz%0d_inc_mask got=%h exp=%h", z, inc_mask, (z == 1) ? 8'h50 : 8'h10);
            else pass_cnt++;
        end
    endtask

    task automatic test_jmp();
        snap_t e;
        logic [7:0] pc_mask;
        logic [7:0] mem_mask;
        pc_mask = '0; mem_mask = '0;
        opcode = OP_JMP; mem_rdy = 1'b1; zero = 1'b1;
        for (int c = 0; c < 8; c++) begin
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL jmp_cyc%0d got=%h exp=%h", c, got, e);
            else pass_cnt++;
            if (ld_pc) pc_mask[phase] = 1'b1;
            if (rd || wr) mem_mask[phase] = 1'b1;
            finish_cycle();
        end
        total_cnt++;
        if (pc_mask !== 8'hC0) $display("[TB] FAIL jmp_ldpc_mask got=%h exp=c0", pc_mask);
        else pass_cnt++;
        total_cnt++;
        if ((mem_mask & 8'hF0) !== 8'h00) $display("[TB] FAIL jmp_mem_mask got=%h exp=00", mem_mask & 8'hF0);
        else pass_cnt++;
    endtask

    task automatic test_sto_wait();
        snap_t e;
        logic [7:0] cnt0;
        int cyc;
        int stalls;
        int wr_cycles;
        cnt0 = instr_cnt; cyc = 0; stalls = 0; wr_cycles = 0;
        opcode = OP_STO; zero = 1'b0;
        while (cyc < 20) begin
            mem_rdy = !(m_phase == 3'd7 && stalls < 3);
            if (!mem_rdy) stalls++;
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL sto_cyc%0d got=%h exp=%h", cyc, got, e);
            else pass_cnt++;
            if (phase == 3'd7 && wr && data_e) wr_cycles++;
            finish_cycle();
            cyc++;
            if (instr_cnt !== cnt0) break;
        end
        total_cnt++;
        if (cyc != 11) $display("[TB] FAIL sto_latency got=%0d exp=11", cyc);
        else pass_cnt++;
        total_cnt++;
        if (wr_cycles != 4) $display("[TB] FAIL sto_wr_cycles got=%0d exp=4", wr_cycles);
        else pass_cnt++;
        mem_rdy = 1'b1;
    endtask

    task automatic test_ready_at_limit();
        snap_t e;
        opcode = OP_XOR; zero = 1'b0;
        for (int c = 0; c < 22; c++) begin
            mem_rdy = !(c >= 1 && c <= 14);
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL limit_cyc%0d got=%h exp=%h", c, got, e);
            else pass_cnt++;
            finish_cycle();
        end
        total_cnt++;
        if (bus_err !== 1'b0 || phase !== 3'd0)
            $display("[TB] FAIL limit_no_error got=%b/%0d exp=0/0", bus_err, phase);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        snap_t e;
        int ok_waits;
        ok_waits = 0;
        opcode = OP_ADD; zero = 1'b0;
        for (int c = 0; c < 21; c++) begin
            mem_rdy = (c == 0);
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL tmo_cyc%0d got=%h exp=%h", c, got, e);
            else pass_cnt++;
            if (c > 0 && phase == 3'd1 && bus_err == 1'b0) ok_waits++;
            if (c > 16) begin
                mem_rdy = 1'b1;
                opcode  = OP_STO;
            end
            finish_cycle();
        end
        total_cnt++;
        if (ok_waits != WAIT_MAX) $display("[TB] FAIL tmo_wait_cycles got=%0d exp=%0d", ok_waits, WAIT_MAX);
        else pass_cnt++;
        total_cnt++;
        if ({sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, bus_err} !== 10'b0000000011)
            $display("[TB] FAIL tmo_halted got=%b exp=0000000011",
                     {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, bus_err});
        else pass_cnt++;
        rst_n = 1'b0;
        model_reset();
        push_cycle();
        e = exp_q.pop_front();
        total_cnt++;
        if (got !== e) $display("[TB] FAIL tmo_reset got=%h exp=%h", got, e);
        else pass_cnt++;
        finish_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_hlt();
        snap_t e;
        int frozen;
        frozen = 0;
        opcode = OP_HLT; mem_rdy = 1'b1; zero = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (c > 5) begin
                mem_rdy = 1'($urandom_range(1));
                zero    = 1'($urandom_range(1));
                opcode  = 3'($urandom_range(7));
            end
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL hlt_cyc%0d got=%h exp=%h", c, got, e);
            else pass_cnt++;
            if (c >= 4 && phase == 3'd4 && halt && !inc_pc) frozen++;
            finish_cycle();
        end
        total_cnt++;
        if (frozen != 21) $display("[TB] FAIL hlt_frozen got=%0d exp=21", frozen);
        else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_back_to_back();
        snap_t e;
        logic [2:0] prev;
        int retired;
        int cyc;
        retired = 0; cyc = 0;
        opcode = OP_ADD;
        while (retired < 256 && cyc < 8000) begin
            mem_rdy = ($urandom_range(3) != 0);
            zero    = 1'($urandom_range(1));
            push_cycle();
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== e) $display("[TB] FAIL b2b_cyc%0d got=%h exp=%h", cyc, got, e);
            else pass_cnt++;
            if (retired == 255 && phase == 3'd7) begin
                total_cnt++;
                if (instr_cnt !== 8'd255) $display("[TB] FAIL b2b_cnt255 got=%0d exp=255", instr_cnt);
                else pass_cnt++;
            end
            prev = m_phase;
            finish_cycle();
            if (prev == 3'd7 && m_phase == 3'd0) retired++;
            cyc++;
        end
        total_cnt++;
        if (retired != 256) $display("[TB] FAIL b2b_budget got=%0d exp=256", retired);
        else pass_cnt++;
        total_cnt++;
        if (instr_cnt !== 8'd0 || bus_err !== 1'b0)
            $display("[TB] FAIL b2b_wrap got=%0d/%b exp=0/0", instr_cnt, bus_err);
        else pass_cnt++;
    endtask

    initial begin
        rst_n   = 1'b1;
        opcode  = OP_ADD;
        zero    = 1'b0;
        mem_rdy = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        apply_reset();
        test_add();
        test_skz();
        test_jmp();
        test_sto_wait();
        test_ready_at_limit();
        test_timeout();
        test_hlt();
        test_back_to_back();

        total_cnt++;
        if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
